instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 81 ++++++++
 tb/tb_instr_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 12-bit instructions from memory at pc and
// hands each one downstream through a valid/ready register (K).
//
// state | meaning
// IDLE  | no fetch pending, K not valid; waits for run
// FETCH | mem_req high at pc until mem_ack loads K
// HOLD  | K valid, waits for downstream consume (optional jump)
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [11:0] mem_data,
    output logic [11:0] K,
    output logic        k_valid,
    input  logic        k_ready,
    input  logic        jmp_en,
    input  logic [7:0]  jmp_addr,
    output logic [7:0]  pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [7:0]  pc_q, pc_next;
    logic [11:0] k_q, k_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            k_q   <= 12'h000;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            k_q   <= k_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        k_next     = k_q;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    k_next     = mem_data;
                    pc_next    = pc_q + 8'd1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // A jump taken at consume replaces the post-fetch increment.
                if (k_ready) begin
                    state_next = run ? FETCH : IDLE;
                    if (jmp_en) pc_next = jmp_addr;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode straight from the state so reset clears them without a clock.
    assign mem_req  = (state == FETCH);
    assign mem_addr = pc_q;
    assign k_valid  = (state == HOLD);
    assign K        = k_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written
// reset-during-fetch sequence.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [11:0] mem_data;
    logic [11:0] K;
    logic        k_valid;
    logic        k_ready;
    logic        jmp_en;
    logic [7:0]  jmp_addr;
    logic [7:0]  pc;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch #(.RESET_PC(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .K        (K),
        .k_valid  (k_valid),
        .k_ready  (k_ready),
        .jmp_en   (jmp_en),
        .jmp_addr (jmp_addr),
        .pc       (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        ack;
        logic [11:0] data;
        logic        rdy;
        logic        jen;
        logic [7:0]  jaddr;
        logic        req;
        logic [7:0]  addr;
        logic [11:0] k;
        logic        kv;
        logic [7:0]  pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic a, logic [11:0] d, logic rd, logic je,
                                logic [7:0] ja, logic rq, logic [7:0] ad,
                                logic [11:0] k, logic kv, logic [7:0] p);
        vec_t v;
        v.run = r; v.ack = a; v.data = d; v.rdy = rd; v.jen = je; v.jaddr = ja;
        v.req = rq; v.addr = ad; v.k = k; v.kv = kv; v.pc = p;
        return v;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_outs(string tag, logic rq, logic [7:0] ad, logic [11:0] k,
                              logic kv, logic [7:0] p);
        check({tag, ".mem_req"}, {11'h0, mem_req}, {11'h0, rq});
        if (rq) check({tag, ".mem_addr"}, {4'h0, mem_addr}, {4'h0, ad});
        check({tag, ".K"}, K, k);
        check({tag, ".k_valid"}, {11'h0, k_valid}, {11'h0, kv});
        check({tag, ".pc"}, {4'h0, pc}, {4'h0, p});
    endtask

    task automatic drive(logic r, logic a, logic [11:0] d, logic rd, logic je, logic [7:0] ja);
        run = r; mem_ack = a; mem_data = d; k_ready = rd; jmp_en = je; jmp_addr = ja;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          run ack data    rdy jen jaddr  | req addr   K       kv pc
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 8'h00, 1, 8'h00, 12'h000, 0, 8'h00));
        vecs.push_back(mk(1, 1, 12'h005, 0, 0, 8'h00, 0, 8'h00, 12'h005, 1, 8'h01));
        vecs.push_back(mk(1, 1, 12'hABC, 0, 1, 8'h77, 0, 8'h00, 12'h005, 1, 8'h01));
        vecs.push_back(mk(1, 0, 12'h000, 1, 0, 8'h00, 1, 8'h01, 12'h005, 0, 8'h01));
        vecs.push_back(mk(1, 1, 12'hFFF, 0, 1, 8'h33, 0, 8'h00, 12'hFFF, 1, 8'h02));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 12'h000, 0, 0, 8'h00, 0, 8'h00, 12'hFFF, 1, 8'h02));
        vecs.push_back(mk(1, 0, 12'h000, 1, 0, 8'h00, 1, 8'h02, 12'hFFF, 0, 8'h02));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 12'h000, 0, 0, 8'h00, 1, 8'h02, 12'hFFF, 0, 8'h02));
        vecs.push_back(mk(1, 1, 12'h123, 0, 0, 8'h00, 0, 8'h00, 12'h123, 1, 8'h03));
        vecs.push_back(mk(1, 0, 12'h000, 1, 1, 8'h40, 1, 8'h40, 12'h123, 0, 8'h40));
        vecs.push_back(mk(1, 1, 12'h456, 0, 0, 8'h00, 0, 8'h00, 12'h456, 1, 8'h41));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 8'h00, 0, 8'h00, 12'h456, 0, 8'h41));
        vecs.push_back(mk(0, 1, 12'h999, 0, 1, 8'h10, 0, 8'h00, 12'h456, 0, 8'h41));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 8'h00, 1, 8'h41, 12'h456, 0, 8'h41));
        vecs.push_back(mk(1, 1, 12'h111, 0, 0, 8'h00, 0, 8'h00, 12'h111, 1, 8'h42));
        vecs.push_back(mk(1, 0, 12'h000, 1, 1, 8'hFF, 1, 8'hFF, 12'h111, 0, 8'hFF));
        vecs.push_back(mk(1, 1, 12'hFE7, 0, 0, 8'h00, 0, 8'h00, 12'hFE7, 1, 8'h00));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 8'h00, 0, 8'h00, 12'hFE7, 0, 8'h00));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h00, 12'hFE7, 0, 8'h00));

        rst = 1'b1;
        drive(0, 0, 12'h000, 0, 0, 8'h00);
        #2;
        check_outs("reset", 1'b0, 8'h00, 12'h000, 1'b0, 8'h00);
        check("reset.mem_addr", {4'h0, mem_addr}, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].jen, vecs[i].jaddr);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].k,
                       vecs[i].kv, vecs[i].pc);
        end

        // Reach a fetch at 8'h12, then reset asynchronously mid-request.
        drive(1, 0, 12'h000, 0, 0, 8'h00);
        step();
        check_outs("pre12.fetch", 1'b1, 8'h00, 12'hFE7, 1'b0, 8'h00);
        drive(1, 1, 12'h222, 0, 0, 8'h00);
        step();
        check_outs("pre12.hold", 1'b0, 8'h00, 12'h222, 1'b1, 8'h01);
        drive(1, 0, 12'h000, 1, 1, 8'h12);
        step();
        check_outs("fetch12", 1'b1, 8'h12, 12'h222, 1'b0, 8'h12);

        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 12'h000, 0, 0, 8'h00);
        #1;
        check_outs("async_rst", 1'b0, 8'h00, 12'h000, 1'b0, 8'h00);
        check("async_rst.mem_addr", {4'h0, mem_addr}, 12'h000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_outs("post_rst.fetch", 1'b1, 8'h00, 12'h000, 1'b0, 8'h00);
        drive(1, 1, 12'hFCB, 0, 0, 8'h00);
        step();
        check_outs("post_rst.hold", 1'b0, 8'h00, 12'hFCB, 1'b1, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
